// File: rtl/wired_axi_pkg.sv
// Shared AXI read-channel types, arbiter state encoding and protocol constants
// for the wired read arbiter.
package wired_axi_pkg;

  localparam int unsigned AxiIdW   = 4;
  localparam int unsigned AxiAddrW = 32;
  localparam int unsigned AxiDataW = 32;
  localparam int unsigned AxiLenW  = 8;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExOkay = 2'b01;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiAddrW-1:0] addr;
    logic [AxiLenW-1:0]  len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic                lock;
    logic [3:0]          cache;
    logic [2:0]          prot;
  } axi_ar_t;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiDataW-1:0] data;
    logic [1:0]          resp;
    logic                last;
  } axi_r_t;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData
  } arb_state_e;

endpackage

// File: rtl/wired_rr_arb2.sv
// Two-way grant: round-robin (pointer flips to the loser on advance) or fixed
// priority with requester 0 winning ties.
module wired_rr_arb2 #(
  parameter bit FixedPrio = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  input  logic       adv_idx_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o
);

  // ptr_q == 0 favours requester 0 on a tie
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_idx_o = 1'b0;
    gnt_o     = 2'b00;
    if (req_i == 2'b11) begin
      gnt_idx_o = FixedPrio ? 1'b0 : ptr_q;
    end else begin
      gnt_idx_o = req_i[1];
    end
    if (req_i != 2'b00) begin
      gnt_o = gnt_idx_o ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = ~adv_idx_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/wired_axi_rd_arb.sv
// Two-requester AXI read arbiter, one burst in flight. Define
// WIRED_AXI_RD_ARB_WR_ORDER_EN to hold off s1 grants while writes are outstanding.
module wired_axi_rd_arb
  import wired_axi_pkg::*;
#(
  parameter int unsigned ID_W       = 4,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic    clk,
  input  logic    rst_n,
  input  axi_ar_t s0_ar_i,
  input  logic    s0_ar_valid_i,
  output logic    s0_ar_ready_o,
  output axi_r_t  s0_r_o,
  output logic    s0_r_valid_o,
  input  logic    s0_r_ready_i,
  input  axi_ar_t s1_ar_i,
  input  logic    s1_ar_valid_i,
  output logic    s1_ar_ready_o,
  output axi_r_t  s1_r_o,
  output logic    s1_r_valid_o,
  input  logic    s1_r_ready_i,
  output axi_ar_t m_ar_o,
  output logic    m_ar_valid_o,
  input  logic    m_ar_ready_i,
  input  axi_r_t  m_r_i,
  input  logic    m_r_valid_i,
  output logic    m_r_ready_o,
  input  logic    wr_busy_i,
  output logic    proto_err_o
);

  arb_state_e           state_q, state_d;
  axi_ar_t              ar_q, ar_d;
  logic                 win_q, win_d;
  logic [AxiLenW-1:0]   cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [1:0]           req, gnt;
  logic                 gnt_idx;
  logic                 advance;
  logic                 s1_block;
  logic [AxiIdW-1:0]    win_id;

`ifdef WIRED_AXI_RD_ARB_WR_ORDER_EN
  // Data reads wait for outstanding writes so a store-then-load sees its store.
  assign s1_block = wr_busy_i;
`else
  logic unused_wr_busy;
  assign unused_wr_busy = wr_busy_i;
  assign s1_block       = 1'b0;
`endif

  assign req    = {s1_ar_valid_i & ~s1_block, s0_ar_valid_i};
  assign win_id = AxiIdW'(ID_W'(win_q));

  wired_rr_arb2 #(
    .FixedPrio (FIXED_PRIO != 0)
  ) u_rr_arb2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .advance_i (advance),
    .adv_idx_i (win_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign m_ar_o      = ar_q;
  assign s0_r_o      = m_r_i;
  assign s1_r_o      = m_r_i;
  assign proto_err_o = err_q;

  always_comb begin
    state_d       = state_q;
    ar_d          = ar_q;
    win_d         = win_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    advance       = 1'b0;
    s0_ar_ready_o = 1'b0;
    s1_ar_ready_o = 1'b0;
    m_ar_valid_o  = 1'b0;
    m_r_ready_o   = 1'b0;
    s0_r_valid_o  = 1'b0;
    s1_r_valid_o  = 1'b0;
    // Handshakes are suppressed while reset is low so no requester sees a grant
    if (rst_n) begin
      unique case (state_q)
        StIdle: begin
          if (gnt != 2'b00) begin
            s0_ar_ready_o = gnt[0];
            s1_ar_ready_o = gnt[1];
            ar_d          = gnt_idx ? s1_ar_i : s0_ar_i;
            ar_d.id       = AxiIdW'(ID_W'(gnt_idx));
            win_d         = gnt_idx;
            cnt_d         = ar_d.len;
            state_d       = StAddr;
          end
        end
        StAddr: begin
          m_ar_valid_o = 1'b1;
          if (m_ar_ready_i) begin
            state_d = StData;
          end
        end
        StData: begin
          m_r_ready_o  = win_q ? s1_r_ready_i : s0_r_ready_i;
          s0_r_valid_o = ~win_q & m_r_valid_i;
          s1_r_valid_o = win_q & m_r_valid_i;
          if (m_r_valid_i && m_r_ready_o) begin
            cnt_d = cnt_q - 8'd1;
            if ((m_r_i.last && cnt_q != '0) || (!m_r_i.last && cnt_q == '0) ||
                (m_r_i.id != win_id)) begin
              err_d = 1'b1;
            end
            if (m_r_i.last) begin
              state_d = StIdle;
              advance = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ar_q    <= '0;
      win_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ar_q    <= ar_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule
